led_frame_sequencer: RTL

Controller that drives the 24-bit GRB shift register and produces the WS2812-style single-wire output to the LED chain. It issues the register's load and rotate-left strobes and times each bit's high and low phases. It counts 24 bits per LED across a fixed-length chain, then holds the line low for the latch period. It sits between the game/auto/switch colour sources and the LED pin, and replaces the free-running bit sequencing.

---
 rtl/led_timing_pkg.sv | 19 +
 rtl/led_frame_sequencer_if.sv | 38 +++
 rtl/led_bit_timer.sv | 54 +++++
 rtl/led_frame_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/led_timing_pkg.sv
// Shared definitions for the LED frame sequencer.
//   state_t      : sequencer FSM states
//   *_DEF        : default bit/latch timing in cycles at 100 MHz
//   cnt_w()      : width of an unsigned counter that must hold 0..max_val
package led_timing_pkg;

  typedef enum logic [2:0] {INIT, IDLE, LOAD, BIT, LATCH} state_t;

  localparam int T0H_CYC_DEF   = 35;
  localparam int T1H_CYC_DEF   = 70;
  localparam int BIT_CYC_DEF   = 125;
  localparam int LATCH_CYC_DEF = 5000;
  localparam int BITS_PER_LED  = 24;

  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Handshake/strobe bundle between the frame sequencer, its colour
// shift register and the frame requester.
//   start, repeat_en      : frame request / auto-repeat
//   CurrentBit            : MSB of the GRB shift register
//   LoadRegister          : load strobe to the shift register
//   RotateRegisterLeft    : rotate strobe to the shift register
//   led_sel               : LED index captured by the next load
//   dout                  : serial line to the chain
//   busy, frame_done      : status
// modport slave is the sequencer; modport master is its environment.
interface led_frame_sequencer_if
  import led_timing_pkg::*;
#(
  parameter int NUM_LEDS = 8
);
  localparam int LED_W = cnt_w(NUM_LEDS - 1);

  logic             start;
  logic             repeat_en;
  logic             CurrentBit;
  logic             LoadRegister;
  logic             RotateRegisterLeft;
  logic [LED_W-1:0] led_sel;
  logic             dout;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, repeat_en, CurrentBit,
    input  LoadRegister, RotateRegisterLeft, led_sel, dout, busy, frame_done
  );

  modport slave (
    input  start, repeat_en, CurrentBit,
    output LoadRegister, RotateRegisterLeft, led_sel, dout, busy, frame_done
  );

endinterface

// File: rtl/led_bit_timer.sv
// Per-bit timer: counts cyc 0..BIT_CYC-1 while run_i is high and
// generates the registered serial output.
//   clk, rst_n  : clock, async active-low reset
//   run_i       : sequencer is in BIT
//   cur_bit_i   : value of the bit being sent
//   dout_o      : registered serial line
//   bit_end_o   : high in the last cycle of each bit
module led_bit_timer
  import led_timing_pkg::*;
#(
  parameter int T0H_CYC = T0H_CYC_DEF,
  parameter int T1H_CYC = T1H_CYC_DEF,
  parameter int BIT_CYC = BIT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic cur_bit_i,
  output logic dout_o,
  output logic bit_end_o
);

  localparam int CYC_W = cnt_w(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] T0H      = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] T1H      = CYC_W'(T1H_CYC);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             dout_q, dout_d;

  // cyc is held at 0 outside BIT so the first BIT cycle always starts at 0.
  always_comb begin
    cyc_d  = '0;
    dout_d = 1'b0;
    if (run_i) begin
      if (cyc_q != CYC_LAST) cyc_d = cyc_q + CYC_W'(1);
      dout_d = (cyc_q < (cur_bit_i ? T1H : T0H));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o    = dout_q;
  assign bit_end_o = run_i && (cyc_q == CYC_LAST);

endmodule

// File: rtl/led_frame_sequencer.sv
// WS2812-style frame sequencer: loads/rotates the external GRB shift
// register, counts 24 bits per LED over NUM_LEDS LEDs and holds the line
// low for LATCH_CYC after every frame and after reset.
//   clk, reset : clock, async active-low reset
//   bus        : strobes, status and serial line (slave modport)
//
// state | meaning
// INIT  | post-reset latch, line low for LATCH_CYC
// IDLE  | waiting for start
// LOAD  | one-cycle load of LED 0 word
// BIT   | shifting bits out
// LATCH | end-of-frame low period
module led_frame_sequencer
  import led_timing_pkg::*;
#(
  parameter int T0H_CYC   = T0H_CYC_DEF,
  parameter int T1H_CYC   = T1H_CYC_DEF,
  parameter int BIT_CYC   = BIT_CYC_DEF,
  parameter int LATCH_CYC = LATCH_CYC_DEF,
  parameter int NUM_LEDS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  led_frame_sequencer_if.slave  bus
);

  localparam int LED_W  = cnt_w(NUM_LEDS - 1);
  localparam int BIDX_W = cnt_w(BITS_PER_LED - 1);
  localparam int LAT_W  = cnt_w(LATCH_CYC - 1);
  localparam logic [LED_W-1:0]  LED_LAST  = LED_W'(NUM_LEDS - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BITS_PER_LED - 1);
  localparam logic [BIDX_W-1:0] BIDX_PRE  = BIDX_W'(BITS_PER_LED - 2);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATCH_CYC - 1);

  state_t            state_q, state_d;
  logic [BIDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
  logic [LED_W-1:0]  led_sel_q, led_sel_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              load, rot, bit_end, lat_end, last_bit, last_led;

  led_bit_timer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (reset),
    .run_i     (state_q == BIT),
    .cur_bit_i (bus.CurrentBit),
    .dout_o    (bus.dout),
    .bit_end_o (bit_end)
  );

  assign lat_end  = (lat_cnt_q == LAT_LAST);
  assign last_bit = (bit_idx_q == BIDX_LAST);
  assign last_led = (led_cnt_q == LED_LAST);

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    led_cnt_d    = led_cnt_q;
    led_sel_d    = led_sel_q;
    lat_cnt_d    = '0;
    frame_done_d = 1'b0;
    load         = 1'b0;
    rot          = 1'b0;
    unique case (state_q)
      INIT: begin
        if (lat_end) state_d = IDLE;
        else         lat_cnt_d = lat_cnt_q + LAT_W'(1);
      end
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_d = BIT;
      end
      BIT: begin
        if (bit_end) begin
          if (!last_bit) begin
            rot       = 1'b1;
            bit_idx_d = bit_idx_q + BIDX_W'(1);
            // led_sel moves one bit early so it is stable during the reload.
            if (bit_idx_q == BIDX_PRE && !last_led) led_sel_d = led_cnt_q + LED_W'(1);
          end else begin
            bit_idx_d = '0;
            if (last_led) begin
              led_cnt_d = '0;
              led_sel_d = '0;
              state_d   = LATCH;
            end else begin
              // Reload replaces the 24th rotate: no gap between LEDs.
              load      = 1'b1;
              led_cnt_d = led_cnt_q + LED_W'(1);
            end
          end
        end
      end
      LATCH: begin
        if (lat_end) begin
          if (bus.repeat_en) begin
            state_d = LOAD;
          end else begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= INIT;
      bit_idx_q    <= '0;
      led_cnt_q    <= '0;
      led_sel_q    <= '0;
      lat_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      led_cnt_q    <= led_cnt_d;
      led_sel_q    <= led_sel_d;
      lat_cnt_q    <= lat_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.LoadRegister       = load;
  assign bus.RotateRegisterLeft = rot;
  assign bus.led_sel            = led_sel_q;
  assign bus.busy               = (state_q != IDLE);
  assign bus.frame_done         = frame_done_q;

endmodule
